// File: rtl/cursor_step_ctrl_pkg.sv
// rtl/cursor_step_ctrl_pkg.sv - shared state/direction encodings and arbiter helper
package cursor_step_ctrl_pkg;

    localparam int DEF_DEBOUNCE_CYCLES = 650000;
    localparam int DEF_REPEAT_DELAY    = 32500000;
    localparam int DEF_REPEAT_PERIOD   = 6500000;
    localparam int DEF_CNT_W           = 25;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        DELAY = 2'd2,
        RPT   = 2'd3
    } state_t;

    // Direction codes double as bit indices into the debounced level vector.
    typedef enum logic [1:0] {
        DIR_DOWN  = 2'd0,
        DIR_UP    = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    function automatic dir_t pick_dir(input logic [3:0] lvl);
        if (lvl[DIR_DOWN])     return DIR_DOWN;
        else if (lvl[DIR_UP])  return DIR_UP;
        else if (lvl[DIR_LEFT]) return DIR_LEFT;
        else                   return DIR_RIGHT;
    endfunction

endpackage

// File: rtl/cursor_step_ctrl_if.sv
// rtl/cursor_step_ctrl_if.sv - step/override/corner controls toward the corner-adjust datapath
interface cursor_step_if;
    logic up;
    logic down;
    logic left;
    logic right;
    logic override;
    logic switch0;
    logic switch1;
    logic busy;

    modport master (output up, down, left, right, override, switch0, switch1, busy);
    modport slave  (input  up, down, left, right, override, switch0, switch1, busy);
endinterface

// File: rtl/cursor_step_ctrl_button_debounce.sv
// rtl/cursor_step_ctrl_button_debounce.sv - 2-FF synchroniser plus stable-level debouncer
module button_debounce #(
    parameter int CYCLES = 650000,
    parameter int CNT_W  = 25
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout,
    output logic rise
);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt;

    // cnt counts consecutive cycles the synchronised level disagrees with dout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            cnt    <= '0;
            dout   <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], din};
            rise   <= 1'b0;
            if (sync_q[1] == dout) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(CYCLES - 1)) begin
                cnt  <= '0;
                dout <= sync_q[1];
                rise <= sync_q[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cursor_step_ctrl.sv
// rtl/cursor_step_ctrl.sv - button front end: debounce, arbitration, auto-repeat, override toggle
module cursor_step_ctrl
    import cursor_step_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          btn_up,
    input  logic          btn_down,
    input  logic          btn_left,
    input  logic          btn_right,
    input  logic          btn_enter,
    input  logic [1:0]    sw_corner,
    cursor_step_if.master step
);

    logic [3:0]       lvl;
    logic [3:0]       unused_rise;
    logic             unused_enter_lvl;
    logic             enter_rise;
    logic [1:0]       sw_s1, sw_s2;
    logic [1:0]       corner_q;
    logic             override_q, arm;
    logic             up_q, down_q, left_q, right_q, busy_q;
    state_t           state, state_n;
    dir_t             dir_q, dir_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             fire;

    button_debounce #(.CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_down (
        .clk(clk), .reset_n(reset_n), .din(btn_down),  .dout(lvl[DIR_DOWN]),  .rise(unused_rise[0]));
    button_debounce #(.CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_up (
        .clk(clk), .reset_n(reset_n), .din(btn_up),    .dout(lvl[DIR_UP]),    .rise(unused_rise[1]));
    button_debounce #(.CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_left (
        .clk(clk), .reset_n(reset_n), .din(btn_left),  .dout(lvl[DIR_LEFT]),  .rise(unused_rise[2]));
    button_debounce #(.CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_right (
        .clk(clk), .reset_n(reset_n), .din(btn_right), .dout(lvl[DIR_RIGHT]), .rise(unused_rise[3]));
    button_debounce #(.CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_enter (
        .clk(clk), .reset_n(reset_n), .din(btn_enter), .dout(unused_enter_lvl), .rise(enter_rise));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Release wins over a coinciding terminal count; override loss wins over everything.
    always_comb begin
        state_n = state;
        dir_n   = dir_q;
        cnt_n   = cnt;
        fire    = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (arm && (|lvl)) begin
                    state_n = FIRST;
                    dir_n   = pick_dir(lvl);
                end
            end
            FIRST: begin
                cnt_n = '0;
                if (!lvl[dir_q]) begin
                    state_n = IDLE;
                end else begin
                    fire    = 1'b1;
                    state_n = DELAY;
                end
            end
            DELAY, RPT: begin
                if (!lvl[dir_q]) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == CNT_W'((state == DELAY) ? REPEAT_DELAY - 1 : REPEAT_PERIOD - 1)) begin
                    fire    = 1'b1;
                    cnt_n   = '0;
                    state_n = RPT;
                end else if (!(&cnt)) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (!override_q) begin
            state_n = IDLE;
            fire    = 1'b0;
            cnt_n   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dir_q      <= DIR_DOWN;
            cnt        <= '0;
            sw_s1      <= '0;
            sw_s2      <= '0;
            corner_q   <= '0;
            override_q <= 1'b0;
            arm        <= 1'b0;
            up_q       <= 1'b0;
            down_q     <= 1'b0;
            left_q     <= 1'b0;
            right_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            dir_q   <= dir_n;
            cnt     <= cnt_n;
            sw_s1   <= sw_corner;
            sw_s2   <= sw_s1;
            up_q    <= fire && (dir_q == DIR_UP);
            down_q  <= fire && (dir_q == DIR_DOWN);
            left_q  <= fire && (dir_q == DIR_LEFT);
            right_q <= fire && (dir_q == DIR_RIGHT);
            busy_q  <= (state_n != IDLE);
            if (state == IDLE) begin
                corner_q <= sw_s2;
            end
            // arm lags a rising override by one cycle but drops together with it.
            if (enter_rise) begin
                override_q <= ~override_q;
                arm        <= 1'b0;
            end else begin
                arm <= override_q;
            end
        end
    end

    assign step.up       = up_q;
    assign step.down     = down_q;
    assign step.left     = left_q;
    assign step.right    = right_q;
    assign step.override = override_q;
    assign step.switch0  = corner_q[0];
    assign step.switch1  = corner_q[1];
    assign step.busy     = busy_q;

endmodule
